// File: rtl/mc_control_if.sv
// Control bundle between the multi-cycle MIPS controller (master) and the datapath (slave):
// IR fields and ALU flags in, mux selects and write enables out.
interface mc_control_if #(
    parameter int ALU_OP_W = 4
);
    logic [5:0]          opcode;
    logic [5:0]          funct;
    logic                zeroFlag;
    logic                overflow;
    logic                memReady;
    logic [ALU_OP_W-1:0] aluOp;
    logic                aluSrcA;
    logic [1:0]          aluSrcB;
    logic                pcWrite;
    logic [1:0]          pcSource;
    logic                iorD;
    logic                memRead;
    logic                memWrite;
    logic                irWrite;
    logic                regDst;
    logic                memToReg;
    logic                regWrite;
    logic                excFlag;

    modport master (
        input  opcode, funct, zeroFlag, overflow, memReady,
        output aluOp, aluSrcA, aluSrcB, pcWrite, pcSource, iorD, memRead,
               memWrite, irWrite, regDst, memToReg, regWrite, excFlag
    );

    modport slave (
        output opcode, funct, zeroFlag, overflow, memReady,
        input  aluOp, aluSrcA, aluSrcB, pcWrite, pcSource, iorD, memRead,
               memWrite, irWrite, regDst, memToReg, regWrite, excFlag
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS main controller: Moore decode of state, memReady-stalled memory accesses.
// Define OVERFLOW_TRAP_EN to send signed-overflowing add/sub/addi to the EXC state.
module mc_control_fsm #(
    parameter int ALU_OP_W = 4,
    parameter int STATE_W  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    mc_control_if.master       bus,
    output logic [STATE_W-1:0] state
);
    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = 0,
        S_FETCH  = 1,
        S_DECODE = 2,
        S_MEMADR = 3,
        S_MEMRD  = 4,
        S_MEMWB  = 5,
        S_MEMWR  = 6,
        S_EXEC   = 7,
        S_ALUWB  = 8,
        S_BRANCH = 9,
        S_JUMP   = 10,
        S_ADDIEX = 11,
        S_ADDIWB = 12,
        S_EXC    = 13
    } state_t;

    localparam logic [ALU_OP_W-1:0] ALU_AND = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] ALU_OR  = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(2);
    localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(3);
    localparam logic [ALU_OP_W-1:0] ALU_SLT = ALU_OP_W'(4);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    function automatic logic funct_ok(input logic [5:0] f);
        return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
               (f == FN_OR)  || (f == FN_SLT);
    endfunction

    function automatic logic [ALU_OP_W-1:0] funct_alu(input logic [5:0] f);
        case (f)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

    state_t              state_q, state_d;
    logic [ALU_OP_W-1:0] alu_op;
    logic                alu_src_a, pc_write, ior_d, mem_read, mem_write, ir_write;
    logic                reg_dst, mem_to_reg, reg_write, exc_flag;
    logic [1:0]          alu_src_b, pc_source;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        alu_op     = '0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        pc_write   = 1'b0;
        pc_source  = 2'd0;
        ior_d      = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        exc_flag   = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                alu_op    = ALU_ADD;
                // IR and PC+4 are captured only on the cycle the read completes
                if (bus.memReady) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'd3;
                alu_op    = ALU_ADD;
                case (bus.opcode)
                    OP_RTYPE:     state_d = funct_ok(bus.funct) ? S_EXEC : S_FETCH;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                alu_op    = ALU_ADD;
                state_d   = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                ior_d    = 1'b1;
                if (bus.memReady) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                ior_d     = 1'b1;
                if (bus.memReady) state_d = S_FETCH;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = funct_alu(bus.funct);
                state_d   = S_ALUWB;
`ifdef OVERFLOW_TRAP_EN
                if (bus.overflow && (bus.funct == FN_ADD || bus.funct == FN_SUB))
                    state_d = S_EXC;
`endif
            end
            S_ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_source = 2'd1;
                pc_write  = bus.zeroFlag;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_source = 2'd2;
                pc_write  = 1'b1;
                state_d   = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                alu_op    = ALU_ADD;
                state_d   = S_ADDIWB;
`ifdef OVERFLOW_TRAP_EN
                if (bus.overflow) state_d = S_EXC;
`endif
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_EXC: begin
`ifdef OVERFLOW_TRAP_EN
                exc_flag  = 1'b1;
`else
                exc_flag  = 1'b0;
`endif
                pc_write  = 1'b1;
                pc_source = 2'd3;
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

`ifndef OVERFLOW_TRAP_EN
    logic unused_overflow;
    assign unused_overflow = bus.overflow;
`endif

    assign bus.aluOp    = alu_op;
    assign bus.aluSrcA  = alu_src_a;
    assign bus.aluSrcB  = alu_src_b;
    assign bus.pcWrite  = pc_write;
    assign bus.pcSource = pc_source;
    assign bus.iorD     = ior_d;
    assign bus.memRead  = mem_read;
    assign bus.memWrite = mem_write;
    assign bus.irWrite  = ir_write;
    assign bus.regDst   = reg_dst;
    assign bus.memToReg = mem_to_reg;
    assign bus.regWrite = reg_write;
    assign bus.excFlag  = exc_flag;
    assign state        = state_q;
endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: per-cycle vector table with a scoreboard queue,
// plus hand-written overflow-trap and mid-instruction reset sequences.
module tb_mc_control_fsm;
    typedef logic [17:0] ctl_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       rdy;
        logic       zf;
        logic       ov;
        logic [3:0] st;
        ctl_t       c;
    } vec_t;

    typedef struct {
        logic [3:0] st;
        ctl_t       c;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] state;
    int         checks = 0;
    int         errors = 0;
    vec_t       vecs[$];
    exp_t       exp_q[$];

    ctl_t C_IDLE, C_FETCH_RDY, C_FETCH_STL, C_DECODE, C_MEMADR, C_MEMRD, C_MEMWB, C_MEMWR;
    ctl_t C_ALUWB, C_BR_T, C_BR_N, C_JUMP, C_ADDIEX, C_ADDIWB, C_EXC;

    mc_control_if #(.ALU_OP_W(4)) bus();

    mc_control_fsm #(.ALU_OP_W(4), .STATE_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .state (state)
    );

    always #5 clk = ~clk;

    // Field order: aluOp, aluSrcA, aluSrcB, pcWrite, pcSource, iorD, memRead, memWrite,
    // irWrite, regDst, memToReg, regWrite, excFlag
    function automatic ctl_t mk(input int op, input int sa, input int sb, input int pw,
                                input int ps, input int iord, input int mrd, input int mwr,
                                input int irw, input int rdst, input int m2r, input int rw,
                                input int exc);
        return {op[3:0], sa[0], sb[1:0], pw[0], ps[1:0], iord[0], mrd[0], mwr[0],
                irw[0], rdst[0], m2r[0], rw[0], exc[0]};
    endfunction

    function automatic ctl_t c_exec(input int op);
        return mk(op, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic ctl_t dut_ctl();
        return {bus.aluOp, bus.aluSrcA, bus.aluSrcB, bus.pcWrite, bus.pcSource, bus.iorD,
                bus.memRead, bus.memWrite, bus.irWrite, bus.regDst, bus.memToReg,
                bus.regWrite, bus.excFlag};
    endfunction

    task automatic add(input int op, input int fn, input int rdy, input int zf, input int ov,
                       input int st, input ctl_t c);
        vec_t v;
        v.op = op[5:0]; v.fn = fn[5:0]; v.rdy = rdy[0]; v.zf = zf[0]; v.ov = ov[0];
        v.st = st[3:0]; v.c = c;
        vecs.push_back(v);
    endtask

    task automatic check_out(input string tag, input int idx);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s[%0d] scoreboard: queue empty, required one entry", tag, idx);
        end else begin
            e = exp_q.pop_front();
            checks++;
            if (state !== e.st) begin
                errors++;
                $display("FAIL %s[%0d] state: got %0d required %0d", tag, idx, state, e.st);
            end
            checks++;
            if (dut_ctl() !== e.c) begin
                errors++;
                $display("FAIL %s[%0d] ctl: got %b required %b", tag, idx, dut_ctl(), e.c);
            end
        end
    endtask

    // Drive one cycle of inputs just after the falling edge, check the Moore/qualified
    // outputs mid-cycle, then let the rising edge advance the FSM.
    task automatic apply(input vec_t v, input string tag, input int idx);
        exp_t e;
        bus.opcode   = v.op;
        bus.funct    = v.fn;
        bus.memReady = v.rdy;
        bus.zeroFlag = v.zf;
        bus.overflow = v.ov;
        e.st = v.st; e.c = v.c;
        exp_q.push_back(e);
        #1;
        check_out(tag, idx);
        @(negedge clk);
    endtask

    task automatic run_list(input string tag);
        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], tag, i);
        vecs.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        C_IDLE      = '0;
        C_FETCH_RDY = mk(2, 0, 1, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        C_FETCH_STL = mk(2, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        C_DECODE    = mk(2, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        C_MEMADR    = mk(2, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        C_MEMRD     = mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        C_MEMWB     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        C_MEMWR     = mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        C_ALUWB     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        C_BR_T      = mk(3, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        C_BR_N      = mk(3, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        C_JUMP      = mk(0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
        C_ADDIEX    = mk(2, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        C_ADDIWB    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        C_EXC       = mk(0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 1);

        bus.opcode = '0; bus.funct = '0; bus.memReady = 1'b1;
        bus.zeroFlag = 1'b0; bus.overflow = 1'b0;
        @(negedge clk);

        // Held in reset across edges, then released to IDLE -> FETCH
        add(8'h00, 8'h00, 1, 1, 1, 0, C_IDLE);
        add(8'h00, 8'h00, 1, 1, 1, 0, C_IDLE);
        run_list("reset");
        rst_n = 1'b1;

        // R-type SUB: 1,2,7,8
        add(8'h00, 8'h22, 1, 0, 0, 0, C_IDLE);
        add(8'h00, 8'h22, 1, 0, 0, 1, C_FETCH_RDY);
        add(8'h00, 8'h22, 1, 0, 0, 2, C_DECODE);
        add(8'h00, 8'h22, 1, 0, 0, 7, c_exec(3));
        add(8'h00, 8'h22, 1, 0, 0, 8, C_ALUWB);
        // lw with two memReady=0 cycles in MEMRD
        add(8'h23, 8'h00, 1, 0, 0, 1, C_FETCH_RDY);
        add(8'h23, 8'h00, 1, 0, 0, 2, C_DECODE);
        add(8'h23, 8'h00, 1, 0, 0, 3, C_MEMADR);
        add(8'h23, 8'h00, 0, 0, 0, 4, C_MEMRD);
        add(8'h23, 8'h00, 0, 0, 0, 4, C_MEMRD);
        add(8'h23, 8'h00, 1, 0, 0, 4, C_MEMRD);
        add(8'h23, 8'h00, 1, 0, 0, 5, C_MEMWB);
        // beq taken, with one FETCH stall first
        add(8'h04, 8'h00, 0, 1, 0, 1, C_FETCH_STL);
        add(8'h04, 8'h00, 1, 1, 0, 1, C_FETCH_RDY);
        add(8'h04, 8'h00, 1, 0, 0, 2, C_DECODE);
        add(8'h04, 8'h00, 1, 1, 0, 9, C_BR_T);
        // beq not taken
        add(8'h04, 8'h00, 1, 1, 0, 1, C_FETCH_RDY);
        add(8'h04, 8'h00, 1, 1, 0, 2, C_DECODE);
        add(8'h04, 8'h00, 1, 0, 0, 9, C_BR_N);
        // j
        add(8'h02, 8'h00, 1, 0, 0, 1, C_FETCH_RDY);
        add(8'h02, 8'h00, 1, 0, 0, 2, C_DECODE);
        add(8'h02, 8'h00, 1, 0, 0, 10, C_JUMP);
        // sw, memReady=1 on the MEMWR cycle
        add(8'h2B, 8'h00, 1, 0, 0, 1, C_FETCH_RDY);
        add(8'h2B, 8'h00, 1, 0, 0, 2, C_DECODE);
        add(8'h2B, 8'h00, 1, 0, 0, 3, C_MEMADR);
        add(8'h2B, 8'h00, 1, 0, 0, 6, C_MEMWR);
        // ADD, overflow asserted outside EXEC only
        add(8'h00, 8'h20, 1, 1, 1, 1, C_FETCH_RDY);
        add(8'h00, 8'h20, 1, 1, 1, 2, C_DECODE);
        add(8'h00, 8'h20, 1, 0, 0, 7, c_exec(2));
        add(8'h00, 8'h20, 1, 0, 1, 8, C_ALUWB);
        // AND / OR / SLT never trap, even with overflow=1
        add(8'h00, 8'h24, 1, 0, 0, 1, C_FETCH_RDY);
        add(8'h00, 8'h24, 1, 0, 0, 2, C_DECODE);
        add(8'h00, 8'h24, 1, 0, 1, 7, c_exec(0));
        add(8'h00, 8'h24, 1, 0, 0, 8, C_ALUWB);
        add(8'h00, 8'h25, 1, 0, 0, 1, C_FETCH_RDY);
        add(8'h00, 8'h25, 1, 0, 0, 2, C_DECODE);
        add(8'h00, 8'h25, 1, 0, 1, 7, c_exec(1));
        add(8'h00, 8'h25, 1, 0, 0, 8, C_ALUWB);
        add(8'h00, 8'h2A, 1, 0, 0, 1, C_FETCH_RDY);
        add(8'h00, 8'h2A, 1, 0, 0, 2, C_DECODE);
        add(8'h00, 8'h2A, 1, 0, 1, 7, c_exec(4));
        add(8'h00, 8'h2A, 1, 0, 0, 8, C_ALUWB);
        // Unsupported funct and unsupported opcode fall back to FETCH from DECODE
        add(8'h00, 8'h3F, 1, 0, 0, 1, C_FETCH_RDY);
        add(8'h00, 8'h3F, 1, 0, 0, 2, C_DECODE);
        add(8'h3F, 8'h20, 1, 0, 0, 1, C_FETCH_RDY);
        add(8'h3F, 8'h20, 1, 0, 0, 2, C_DECODE);
        // addi without overflow
        add(8'h08, 8'h00, 1, 0, 0, 1, C_FETCH_RDY);
        add(8'h08, 8'h00, 1, 0, 0, 2, C_DECODE);
        add(8'h08, 8'h00, 1, 0, 0, 11, C_ADDIEX);
        add(8'h08, 8'h00, 1, 0, 1, 12, C_ADDIWB);
        add(8'h08, 8'h00, 1, 0, 0, 1, C_FETCH_RDY);
        run_list("tbl");

        // Overflow in ADDIEX and in EXEC SUB
        add(8'h08, 8'h00, 1, 0, 0, 2, C_DECODE);
        add(8'h08, 8'h00, 1, 0, 1, 11, C_ADDIEX);
`ifdef OVERFLOW_TRAP_EN
        add(8'h08, 8'h00, 1, 0, 0, 13, C_EXC);
`else
        add(8'h08, 8'h00, 1, 0, 0, 12, C_ADDIWB);
`endif
        add(8'h00, 8'h22, 1, 0, 0, 1, C_FETCH_RDY);
        add(8'h00, 8'h22, 1, 0, 0, 2, C_DECODE);
        add(8'h00, 8'h22, 1, 0, 1, 7, c_exec(3));
`ifdef OVERFLOW_TRAP_EN
        add(8'h00, 8'h22, 1, 0, 1, 13, C_EXC);
`else
        add(8'h00, 8'h22, 1, 0, 1, 8, C_ALUWB);
`endif
        add(8'h2B, 8'h00, 1, 0, 0, 1, C_FETCH_RDY);
        add(8'h2B, 8'h00, 1, 0, 0, 2, C_DECODE);
        add(8'h2B, 8'h00, 1, 0, 0, 3, C_MEMADR);
        add(8'h2B, 8'h00, 0, 0, 0, 6, C_MEMWR);
        add(8'h2B, 8'h00, 0, 0, 0, 6, C_MEMWR);
        run_list("seq");

        // Still in MEMWR with memReady=0: asynchronous reset mid-cycle
        bus.memReady = 1'b0;
        #2;
        rst_n = 1'b0;
        exp_q.push_back('{st: 4'd0, c: C_IDLE});
        #1;
        check_out("async_rst", 0);
        checks++;
        if (bus.memWrite !== 1'b0) begin
            errors++;
            $display("FAIL async_rst memWrite: got %b required 0", bus.memWrite);
        end
        @(negedge clk);
        rst_n = 1'b1;
        add(8'h00, 8'h00, 1, 0, 0, 0, C_IDLE);
        add(8'h00, 8'h00, 1, 0, 0, 1, C_FETCH_RDY);
        run_list("post_rst");

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
